// File: rtl/fetch_prefetch_stage_pkg.sv
// Shared constants for the prefetching fetch stage: default widths and reset PC.
package fetch_prefetch_stage_pkg;

  localparam int unsigned INSTR_W            = 32;
  localparam int unsigned DEFAULT_XLEN       = 64;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam logic [63:0] DEFAULT_RESET_ADDR = 64'h0;

endpackage

// File: rtl/fetch_prefetch_stage_sync_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap freely.
module fetch_prefetch_stage_sync_fifo
  import fetch_prefetch_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_XLEN + INSTR_W,
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Fetch stage issuing pipelined OBI reads into a prefetch FIFO that drains into the decode register.
module fetch_prefetch_stage
  import fetch_prefetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN       = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEFAULT_RESET_ADDR),
  parameter int unsigned     FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_addr_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  input  logic               imem_gnt_i,
  output logic [XLEN-1:0]    imem_addr_o,
  output logic               imem_we_o,
  output logic [3:0]         imem_be_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    next_pc_o
);

  localparam int unsigned     AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW         = AW + 1;
  localparam int unsigned     EW         = XLEN + INSTR_W;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic            pending;
  logic            req;

  logic            granted;
  logic            drop;
  logic            push;
  logic            pop;
  logic            req_next;
  logic [CW-1:0]   out_after;
  logic [CW-1:0]   discard_next;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   fifo_count_next;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] target_c;

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;
  assign imem_we_o   = 1'b0;
  assign imem_be_o   = 4'hF;
  assign target_c    = redirect_addr_i & ALIGN_MASK;

  fetch_prefetch_stage_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_i),
    .wdata  ({resp_pc, imem_rdata_i}),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Credits count both buffered words and in-flight reads, so the FIFO can never overflow.
  always_comb begin
    granted         = req & imem_gnt_i;
    out_after       = outstanding + CW'(granted) - CW'(imem_rvalid_i);
    drop            = imem_rvalid_i & ((discard != '0) | redirect_i);
    push            = imem_rvalid_i & ~drop;
    pop             = ~redirect_i & ~fifo_empty & (~stall_i | ~valid_o);
    fifo_count_next = redirect_i ? '0 : (fifo_count + CW'(push) - CW'(pop));
    discard_next    = discard - CW'(imem_rvalid_i & (discard != '0)) + CW'(pending & granted);
    req_next        = (req & ~imem_gnt_i) |
                      ((CW+1)'(out_after) + (CW+1)'(fifo_count_next) < (CW+1)'(FIFO_DEPTH));
  end

  // A held (ungranted) request keeps its address; the redirect target is applied once it is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc    <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      target      <= RESET_ADDR;
      outstanding <= '0;
      discard     <= '0;
      pending     <= 1'b0;
      req         <= 1'b0;
    end else begin
      req         <= req_next;
      outstanding <= out_after;
      if (redirect_i) begin
        discard <= out_after;
        if (req && !imem_gnt_i) begin
          pending <= 1'b1;
          target  <= target_c;
        end else begin
          pending  <= 1'b0;
          fetch_pc <= target_c;
          resp_pc  <= target_c;
        end
      end else begin
        discard <= discard_next;
        if (granted && pending) begin
          pending  <= 1'b0;
          fetch_pc <= target;
          resp_pc  <= target;
        end else begin
          if (granted) fetch_pc <= fetch_pc + XLEN'(4);
          if (push)    resp_pc  <= resp_pc + XLEN'(4);
        end
      end
    end
  end

  // Decode register: redirect clears, otherwise load from the FIFO head when free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      pc_o      <= '0;
      next_pc_o <= '0;
    end else if (redirect_i) begin
      valid_o <= 1'b0;
    end else if (pop) begin
      valid_o   <= 1'b1;
      instr_o   <= head[INSTR_W-1:0];
      pc_o      <= head[EW-1:INSTR_W];
      next_pc_o <= head[EW-1:INSTR_W] + XLEN'(4);
    end else if (!stall_i) begin
      valid_o <= 1'b0;
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rvalid_i |-> (outstanding != '0));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Scoreboarded bench for fetch_prefetch_stage: 64-bit instance with a latency-programmable memory, 32-bit instance for PC wrap.
module tb_fetch_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [63:0] redirect_addr = '0;
  logic [31:0] rdata = '0;
  logic        req, we, valid;
  logic [3:0]  be;
  logic [63:0] addr, pc, next_pc;
  logic [31:0] instr;

  logic        req2, we2, valid2;
  logic        rvalid2 = 1'b0;
  logic [3:0]  be2;
  logic [31:0] addr2, pc2, npc2, instr2;
  logic [31:0] rdata2 = '0;

  typedef struct { logic [63:0] a; int due; } rsp_t;
  rsp_t        mq[$];
  logic [63:0] exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fetch_prefetch_stage #(.XLEN(64), .RESET_ADDR(64'h0), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .stall_i(stall), .imem_req_o(req), .imem_gnt_i(gnt), .imem_addr_o(addr),
    .imem_we_o(we), .imem_be_o(be), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .valid_o(valid), .instr_o(instr), .pc_o(pc), .next_pc_o(next_pc)
  );

  fetch_prefetch_stage #(.XLEN(32), .RESET_ADDR(32'hFFFF_FFFC), .FIFO_DEPTH(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(1'b0), .redirect_addr_i(32'h0),
    .stall_i(1'b0), .imem_req_o(req2), .imem_gnt_i(1'b1), .imem_addr_o(addr2),
    .imem_we_o(we2), .imem_be_o(be2), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .valid_o(valid2), .instr_o(instr2), .pc_o(pc2), .next_pc_o(npc2)
  );

  function automatic logic [31:0] tag(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_A5A5;
  endfunction

  // In-order memory for dut: response sampled by the DUT lat edges after the grant edge.
  initial begin
    logic        g;
    logic [63:0] ga;
    rsp_t        r;
    forever begin
      @(negedge clk);
      g  = req && gnt;
      ga = addr;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        mq.delete();
        rvalid = 1'b0;
      end else begin
        if (g) mq.push_back('{a: ga, due: cyc + lat - 1});
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          r      = mq.pop_front();
          rvalid = 1'b1;
          rdata  = tag(r.a);
        end else begin
          rvalid = 1'b0;
        end
      end
    end
  end

  // Single-cycle memory for dut2, grant always high.
  initial begin
    logic        g2;
    logic [31:0] a2;
    forever begin
      @(negedge clk);
      g2 = req2;
      a2 = addr2;
      @(posedge clk);
      #1;
      rvalid2 = rst_n && g2;
      rdata2  = ~a2;
    end
  end

  // Scoreboard: every word decode consumes must be the next expected PC.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && valid && !stall && !redirect && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e || instr !== tag(e) || next_pc !== e + 64'd4) begin
          n_err++;
          $display("FAIL stream: got pc=%h instr=%h next_pc=%h, want pc=%h instr=%h next_pc=%h",
                   pc, instr, next_pc, e, tag(e), e + 64'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [63:0] a, input int n);
    redirect      = 1'b1;
    redirect_addr = a;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back((a & ~64'h3) + 64'(4 * i));
    step();
    redirect = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    int nv;
    int k;
    bit ok;
    rst_n = 1'b0;
    lat = 1;
    gnt = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(4 * i));
    repeat (2) @(negedge clk);
    n_cmp++; if (req !== 1'b0)    begin n_err++; $display("FAIL reset_req: got %b want 0", req); end
    n_cmp++; if (valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (pc !== 64'h0)    begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_cmp++; if (next_pc !== 64'h0) begin n_err++; $display("FAIL reset_next_pc: got %h want 0", next_pc); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (addr !== 64'h0)  begin n_err++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_cmp++; if (we !== 1'b0 || be !== 4'hF) begin n_err++; $display("FAIL obi_const: got we=%b be=%h want we=0 be=f", we, be); end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!valid && k < 8) begin step(); k++; end
    n_cmp++; if (!valid || k > 4) begin n_err++; $display("FAIL first_valid: got valid=%b after %0d cycles want valid=1 within 4", valid, k); end
    nv = 0;
    for (int i = 0; i < 4; i++) begin step(); if (valid) nv++; end
    n_cmp++; if (nv != 4) begin n_err++; $display("FAIL throughput: got %0d valid cycles want 4", nv); end
    wait_drain(50, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL reset_stream_drain: %0d words left want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    int          late_gnt;
    int          nv;
    bit          ok;
    lat = 1;
    start_stream(64'h100, 20);
    for (int i = 0; i < 8 && !valid; i++) step();
    repeat (2) step();
    stall = 1'b1;
    held = pc;
    late_gnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 6 && req && gnt) late_gnt++;
      step();
      n_cmp++;
      if (!valid || pc !== held) begin n_err++; $display("FAIL stall_hold: got valid=%b pc=%h want valid=1 pc=%h", valid, pc, held); end
    end
    n_cmp++; if (req !== 1'b0 || late_gnt != 0) begin n_err++; $display("FAIL stall_full: got req=%b late grants=%0d want req=0 grants=0", req, late_gnt); end
    stall = 1'b0;
    gnt = 1'b0;
    nv = 0;
    while (valid && nv < 12) begin nv++; step(); end
    n_cmp++; if (nv != 5) begin n_err++; $display("FAIL stall_buffered: got %0d words want 5", nv); end
    gnt = 1'b1;
    wait_drain(80, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_drain: %0d words left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_discard();
    bit ok;
    lat = 3;
    start_stream(64'h40, 0);
    repeat (6) step();
    start_stream(64'h1002, 8);
    wait_drain(80, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL discard_drain: %0d words left want 0", exp_q.size()); end
    lat = 1;
  endtask

  task automatic test_gnt_hold_redirect();
    logic [63:0] old_addr;
    int          k;
    bit          ok;
    lat = 1;
    start_stream(64'h300, 0);
    repeat (4) step();
    gnt = 1'b0;
    step();
    k = 0;
    while (!req && k < 8) begin step(); k++; end
    old_addr = addr;
    n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL hold_req_seen: got req=%b want 1", req); end
    start_stream(64'h2000, 8);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (req !== 1'b1 || addr !== old_addr) begin n_err++; $display("FAIL hold_stable: got req=%b addr=%h want req=1 addr=%h", req, addr, old_addr); end
      step();
    end
    n_cmp++; if (req !== 1'b1 || addr !== old_addr) begin n_err++; $display("FAIL hold_stable: got req=%b addr=%h want req=1 addr=%h", req, addr, old_addr); end
    gnt = 1'b1;
    step();
    n_cmp++; if (req !== 1'b1 || addr !== 64'h2000) begin n_err++; $display("FAIL hold_next_addr: got req=%b addr=%h want req=1 addr=2000", req, addr); end
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_drain: %0d words left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_same_cycle();
    bit ok;
    lat = 1;
    start_stream(64'h500, 0);
    repeat (5) step();
    stall = 1'b1;
    start_stream(64'h3000, 8);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL redirect_stall_valid: got %b want 0", valid); end
    stall = 1'b0;
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL redirect_stall_drain: %0d words left want 0", exp_q.size()); end
    start_stream(64'h4000, 8);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL redirect_rvalid_valid: got %b want 0", valid); end
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL redirect_rvalid_drain: %0d words left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap_reset();
    int k;
    bit ok;
    lat = 1;
    start_stream(64'h800, 0);
    repeat (5) step();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (valid !== 1'b0 || req !== 1'b0) begin n_err++; $display("FAIL midrun_reset: got valid=%b req=%b want 0 0", valid, req); end
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(4 * i));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first_addr: got req=%b addr=%h want req=1 addr=fffffffc", req2, addr2); end
    step();
    n_cmp++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin n_err++; $display("FAIL wrap_next_addr: got req=%b addr=%h want req=1 addr=00000000", req2, addr2); end
    k = 0;
    while (!valid2 && k < 6) begin step(); k++; end
    n_cmp++;
    if (!valid2 || pc2 !== 32'hFFFF_FFFC || npc2 !== 32'h0 || instr2 !== 32'h0000_0003) begin
      n_err++;
      $display("FAIL wrap_word0: got valid=%b pc=%h next_pc=%h instr=%h want 1 fffffffc 00000000 00000003", valid2, pc2, npc2, instr2);
    end
    step();
    n_cmp++;
    if (!valid2 || pc2 !== 32'h0 || npc2 !== 32'h4 || instr2 !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_word1: got valid=%b pc=%h next_pc=%h instr=%h want 1 00000000 00000004 ffffffff", valid2, pc2, npc2, instr2);
    end
    n_cmp++; if (we2 !== 1'b0 || be2 !== 4'hF) begin n_err++; $display("FAIL wrap_obi_const: got we=%b be=%h want 0 f", we2, be2); end
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL midrun_reset_drain: %0d words left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_discard();
    test_gnt_hold_redirect();
    test_redirect_same_cycle();
    test_wrap_reset();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
